// File: rtl/cla_share_arb.sv
// rtl/cla_share_arb.sv - round-robin scheduler sharing one fixed-latency adder between two requesters
// Credits bound issues per requester so a returning sum always finds room in its result FIFO.
module cla_share_arb #(
   parameter int W     = 64,
   parameter int LAT   = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [W-1:0] req_a0,
   input  logic [W-1:0] req_b0,
   input  logic [W-1:0] req_a1,
   input  logic [W-1:0] req_b1,
   output logic         issue_valid,
   output logic [W-1:0] issue_a,
   output logic [W-1:0] issue_b,
   input  logic [W-1:0] sum_in,
   input  logic         cout_in,
   output logic [1:0]   rsp_valid,
   input  logic [1:0]   rsp_ready,
   output logic [W-1:0] rsp_sum0,
   output logic [W-1:0] rsp_sum1,
   output logic [1:0]   rsp_cout,
   output logic         idle
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   logic [CW-1:0] credit_q [2];
   logic [CW-1:0] credit_d [2];
   logic          rr_ptr_q, rr_ptr_d;
   logic          issue_valid_q, issue_valid_d;
   logic [W-1:0]  issue_a_q, issue_a_d, issue_b_q, issue_b_d;
   // Stage 0 lines up with the issue register; stage LAT lines up with sum_in.
   logic [LAT:0]  tag_v_q, tag_v_d, tag_id_q, tag_id_d;
   logic [W:0]    mem_q [2][DEPTH];
   logic [W:0]    mem_d [2][DEPTH];
   logic [PW-1:0] wr_ptr_q [2];
   logic [PW-1:0] wr_ptr_d [2];
   logic [PW-1:0] rd_ptr_q [2];
   logic [PW-1:0] rd_ptr_d [2];
   logic [CW-1:0] count_q [2];
   logic [CW-1:0] count_d [2];

   logic [1:0] eligible, grant, rsp_hs, push;
   logic       grant_any, winner;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         eligible[i] = req_valid[i] & (credit_q[i] != '0);
         rsp_valid[i] = (count_q[i] != '0);
         rsp_hs[i] = rsp_valid[i] & rsp_ready[i];
         push[i] = tag_v_q[LAT] & (tag_id_q[LAT] == 1'(i));
      end
      grant = 2'b00;
      if (eligible[rr_ptr_q]) begin
         grant[rr_ptr_q] = 1'b1;
      end else if (eligible[~rr_ptr_q]) begin
         grant[~rr_ptr_q] = 1'b1;
      end
      grant_any = |grant;
      winner = grant[1];
   end

   assign req_ready = rst ? grant : 2'b00;

   always_comb begin
      credit_d = credit_q;
      rr_ptr_d = rr_ptr_q;
      issue_valid_d = grant_any;
      issue_a_d = issue_a_q;
      issue_b_d = issue_b_q;
      mem_d = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d = count_q;
      if (grant_any) begin
         rr_ptr_d = ~winner;
         issue_a_d = winner ? req_a1 : req_a0;
         issue_b_d = winner ? req_b1 : req_b0;
      end
      tag_v_d = {tag_v_q[LAT-1:0], grant_any};
      tag_id_d = {tag_id_q[LAT-1:0], winner};
      for (int i = 0; i < 2; i++) begin
         case ({grant[i], rsp_hs[i]})
            2'b10:   credit_d[i] = credit_q[i] - CW'(1);
            2'b01:   credit_d[i] = credit_q[i] + CW'(1);
            default: credit_d[i] = credit_q[i];
         endcase
         if (push[i]) begin
            mem_d[i][wr_ptr_q[i]] = {cout_in, sum_in};
            wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
         end
         if (rsp_hs[i]) begin
            rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
         end
         case ({push[i], rsp_hs[i]})
            2'b10:   count_d[i] = count_q[i] + CW'(1);
            2'b01:   count_d[i] = count_q[i] - CW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q <= 1'b0;
         issue_valid_q <= 1'b0;
         issue_a_q <= '0;
         issue_b_q <= '0;
         tag_v_q <= '0;
         tag_id_q <= '0;
         for (int i = 0; i < 2; i++) begin
            credit_q[i] <= CRED_MAX;
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i] <= '0;
            for (int j = 0; j < DEPTH; j++) begin
               mem_q[i][j] <= '0;
            end
         end
      end else begin
         rr_ptr_q <= rr_ptr_d;
         issue_valid_q <= issue_valid_d;
         issue_a_q <= issue_a_d;
         issue_b_q <= issue_b_d;
         tag_v_q <= tag_v_d;
         tag_id_q <= tag_id_d;
         credit_q <= credit_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         mem_q <= mem_d;
      end
   end

   assign issue_valid = issue_valid_q;
   assign issue_a = issue_a_q;
   assign issue_b = issue_b_q;
   assign rsp_sum0 = mem_q[0][rd_ptr_q[0]][W-1:0];
   assign rsp_sum1 = mem_q[1][rd_ptr_q[1]][W-1:0];
   assign rsp_cout = {mem_q[1][rd_ptr_q[1]][W], mem_q[0][rd_ptr_q[0]][W]};
   assign idle = ~|tag_v_q & (count_q[0] == '0) & (count_q[1] == '0);

endmodule
